imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Sequences program loading into the 1024×32 instruction memory before the single-cycle core runs. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes the words to consecutive instruction-memory word addresses from 0. Holds the core in reset while loading and releases it once the program image is complete.

## Interface
- `DEPTH`, 1024: instruction-memory depth in words; maximum accepted word count.
- `AW`, 10: word-address width, equal to clog2(DEPTH).
- `clk` input 1: single clock; all logic rises on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid` input 1: byte on `in_data` is valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mem_we` output 1: one-cycle write strobe to the instruction memory.
- `mem_waddr` output AW: word address of the write.
- `mem_wdata` output 32: word to write.
- `cpu_rst_n` output 1: active-low reset to the core (PC, register file).
- `busy` output 1: high in LEN, LOAD and CHK.
- `done` output 1: high in DONE.
- `err` output 1: high in ERR.

## Operation
- Reset values: `in_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0. State is IDLE, byte index is 0, word counter is 0.
- A byte transfers only when `in_valid && in_ready`. Gaps in `in_valid` stall without data loss. The byte index advances 0..3 and wraps. Byte 0 lands in bits [7:0] and byte 3 in bits [31:24].
- States:
  - IDLE: `in_ready`=0, `cpu_rst_n`=0. `start` moves to LEN.
  - LEN: `in_ready`=1. The first assembled word is the word count N.
    - N=0 goes to DONE with no writes.
    - N>DEPTH goes to ERR.
    - Otherwise goes to LOAD.
  - LOAD: `in_ready`=1. Each assembled word k (k=0..N-1) is written to address k. After word N-1 the loader goes to DONE, or to CHK when the checksum feature is built in.
  - DONE: `in_ready`=0, `cpu_rst_n`=1. `start` returns to LEN and drops `cpu_rst_n` to 0 in the next cycle.
  - ERR: `in_ready`=0, `cpu_rst_n`=0. `start` returns to LEN and clears `err`.
- `start` is ignored in LEN, LOAD and CHK.
- The word counter is AW+1 bits wide, so N=DEPTH (count 1024) is representable. The write address is counter[AW-1:0] and never wraps, because N≤DEPTH.
- Memory words beyond N are left untouched.
- Reset mid-load aborts immediately: back to IDLE, core held in reset. A partially assembled word is discarded.

## Timing
- `mem_we`, `mem_waddr` and `mem_wdata` are registered. `mem_we` pulses for exactly one cycle, the cycle after the 4th byte of a word is handshaken.
- Sustained throughput: 1 byte/cycle, 1 write per 4 cycles. `in_ready` never deasserts inside LEN, LOAD or CHK.
- State transitions take effect the cycle after the 4th byte of the deciding word is handshaken.
  - Last data word: `mem_we` pulse and entry to DONE happen in the same cycle. `cpu_rst_n` goes to 1 in that cycle.
  - LEN to LOAD: the first data byte may be accepted in the cycle immediately after the last count byte.
- `start` is sampled on posedge. `in_ready` rises the cycle after `start` is accepted.

## Configuration
- `IMEM_LOAD_CHECKSUM_EN` defined:
  - After the N data words, state CHK accepts one more 4-byte word.
  - If it equals the XOR of all N data words, the loader goes to DONE; otherwise it goes to ERR.
  - With N=0, the checksum word (expected 0) is still required.
  - The checksum word is never written to memory.
- Undefined: no CHK state and no checksum logic. The loader goes straight from the last data word, or from N=0, to DONE.

## Structure
- Package `imem_pkg`:
  - `IMEM_DEPTH`=1024 and `IMEM_AW`=10.
  - Loader state enum `imem_ld_state_t` {IDLE, LEN, LOAD, CHK, DONE, ERR}.
  - The same constants also size the instruction memory.
- One sub-module, `byte_word_packer`:
  - Byte index and 24-bit shift holding register.
  - Emits a one-cycle `word_valid` with the 32-bit word.
  - Synchronous clear, used on abort or `start`.

## Test plan
- Stream count 3, then words 0x00a00093, 0x00a00113, 0x06300193 with `in_valid` held high. Required: 3 `mem_we` pulses at addresses 0, 1, 2 with those data, spaced 4 cycles apart, then `done`=1 and `cpu_rst_n`=1.
- Same image with `in_valid` toggling every other cycle. Required: identical writes, with no byte lost or duplicated.
- Count 0. Required: DONE with zero `mem_we` pulses; with `IMEM_LOAD_CHECKSUM_EN`, only after a 0x00000000 checksum word.
- Count 1025 (0x00000401). Required: `err`=1, `cpu_rst_n`=0, no writes. A following `start` re-enters LEN.
- Assert `rst_n`=0 after 2 bytes of data word 1. Required: all outputs return to their reset values; a fresh load then writes from address 0.
- With `IMEM_LOAD_CHECKSUM_EN`: count 2, words 0x1 and 0x3.
  - Checksum 0x2 gives DONE.
  - Checksum 0x5 gives ERR with `cpu_rst_n`=0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: instruction-memory geometry and boot-loader state encoding
package imem_pkg;
  localparam int IMEM_DEPTH = 1024;
  localparam int IMEM_AW = 10;
  typedef enum logic [2:0] {IDLE, LEN, LOAD, CHK, DONE, ERR} imem_ld_state_t;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles little-endian 32-bit words from a byte stream
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0] idx;
  logic [23:0] hold;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      hold <= '0;
    end else if (clr) begin
      idx <= '0;
      hold <= '0;
    end else if (en) begin
      idx <= idx + 2'd1;
      hold <= {din, hold[23:8]};
    end
  end
  assign word_valid = en && idx == 2'd3;
  assign word = {din, hold};
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed image into imem, holding the core in reset; IMEM_LOAD_CHECKSUM_EN adds a trailing XOR checksum word
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW = IMEM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);
  imem_ld_state_t state, nxt;
  logic [AW:0] cnt, n;
  logic [31:0] word;
  logic wv, clr, last;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam imem_ld_state_t FIN = CHK;
  logic [31:0] xsum;
`else
  localparam imem_ld_state_t FIN = DONE;
`endif
  assign in_ready = state == LEN || state == LOAD || state == CHK;
  assign busy = in_ready;
  assign done = state == DONE;
  assign err = state == ERR;
  assign cpu_rst_n = done;
  assign clr = start && (state == IDLE || state == DONE || state == ERR);
  assign last = cnt + 1'b1 == n;
  byte_word_packer u_pack (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(in_valid && in_ready),
    .din(in_data), .word_valid(wv), .word(word)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? LEN : state;
      LEN: nxt = !wv ? LEN : word == 32'd0 ? FIN : word > 32'(DEPTH) ? ERR : LOAD;
      LOAD: nxt = wv && last ? FIN : LOAD;
`ifdef IMEM_LOAD_CHECKSUM_EN
      CHK: nxt = !wv ? CHK : word == xsum ? DONE : ERR;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      n <= '0;
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (clr) cnt <= '0;
      if (wv && state == LEN) n <= word[AW:0];
      if (wv && state == LOAD) begin
        mem_we <= 1'b1;
        mem_waddr <= cnt[AW-1:0];
        mem_wdata <= word;
        cnt <= cnt + 1'b1;
      end
    end
  end
`ifdef IMEM_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xsum <= '0;
    else if (clr) xsum <= '0;
    else if (wv && state == LOAD) xsum <= xsum ^ word;
  end
`endif
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader
module tb_imem_boot_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, mem_we, cpu_rst_n, busy, done, err;
  logic [9:0] mem_waddr;
  logic [31:0] mem_wdata;
  typedef struct {logic [9:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  int wcyc[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] img[0:2];

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_t e;
      checks++;
      wcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr %0d data %h, required no write", mem_waddr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_waddr !== e.a || mem_wdata !== e.d) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h", mem_waddr, mem_wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.a = 10'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_image(input int n, input bit gap);
    logic [31:0] x = '0;
    send_word(32'(n), gap);
    for (int k = 0; k < n; k++) begin
      push(k, img[k]);
      x ^= img[k];
      send_word(img[k], gap);
    end
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_word(x, gap);
`endif
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    img[0] = 32'h00a00093;
    img[1] = 32'h00a00113;
    img[2] = 32'h06300193;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_waddr", {22'd0, mem_waddr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", {31'd0, in_ready}, 0);

    // streaming image
    do_start();
    chk("len_in_ready", {31'd0, in_ready}, 1);
    chk("len_busy", {31'd0, busy}, 1);
    wcyc.delete();
    send_image(3, 1'b0);
`ifndef IMEM_LOAD_CHECKSUM_EN
    chk("last_we_with_done", {31'd0, mem_we}, 1);
`endif
    chk("s1_done", {31'd0, done}, 1);
    chk("s1_cpu_rst_n", {31'd0, cpu_rst_n}, 1);
    chk("s1_in_ready", {31'd0, in_ready}, 0);
    drain("s1_drain");
    chk("s1_nwrites", wcyc.size(), 3);
    if (wcyc.size() == 3) begin
      chk("s1_gap01", wcyc[1] - wcyc[0], 4);
      chk("s1_gap12", wcyc[2] - wcyc[1], 4);
    end

    // gapped image; restart must drop cpu_rst_n next cycle
    do_start();
    chk("s2_cpu_rst_n_drop", {31'd0, cpu_rst_n}, 0);
    chk("s2_done_drop", {31'd0, done}, 0);
    send_image(3, 1'b1);
    chk("s2_done", {31'd0, done}, 1);
    drain("s2_drain");

    // empty image
    do_start();
    send_word(32'd0, 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    chk("s3_wait_chk", {31'd0, busy}, 1);
    send_word(32'd0, 1'b0);
`endif
    in_valid = 1'b0;
    chk("s3_done", {31'd0, done}, 1);
    drain("s3_drain");

    // oversize count
    do_start();
    send_word(32'h00000401, 1'b0);
    in_valid = 1'b0;
    chk("s4_err", {31'd0, err}, 1);
    chk("s4_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    chk("s4_in_ready", {31'd0, in_ready}, 0);
    drain("s4_drain");
    do_start();
    chk("s4_err_clear", {31'd0, err}, 0);
    chk("s4_relen", {31'd0, in_ready}, 1);

    // abort mid-word with reset
    push(0, 32'h11223344);
    send_word(32'd3, 1'b0);
    send_word(32'h11223344, 1'b0);
    send_byte(8'haa, 1'b0);
    send_byte(8'hbb, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ab_in_ready", {31'd0, in_ready}, 0);
    chk("ab_mem_wdata", mem_wdata, 0);
    chk("ab_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    chk("ab_busy", {31'd0, busy}, 0);
    chk("ab_done", {31'd0, done}, 0);
    chk("ab_err", {31'd0, err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ab_drain", exp_q.size(), 0);
    img[0] = 32'hcafef00d;
    img[1] = 32'h01020304;
    do_start();
    send_image(2, 1'b0);
    chk("ab_reload_done", {31'd0, done}, 1);
    drain("ab_reload_drain");

`ifdef IMEM_LOAD_CHECKSUM_EN
    foreach (img[k]) img[k] = 32'(k * 2 + 1);
    do_start();
    send_word(32'd2, 1'b0);
    push(0, 32'h1); push(1, 32'h3);
    send_word(32'h1, 1'b0);
    send_word(32'h3, 1'b0);
    send_word(32'h2, 1'b0);
    in_valid = 1'b0;
    chk("ck_good_done", {31'd0, done}, 1);
    do_start();
    send_word(32'd2, 1'b0);
    push(0, 32'h1); push(1, 32'h3);
    send_word(32'h1, 1'b0);
    send_word(32'h3, 1'b0);
    send_word(32'h5, 1'b0);
    in_valid = 1'b0;
    chk("ck_bad_err", {31'd0, err}, 1);
    chk("ck_bad_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    drain("ck_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
